// File: rtl/timer_bus_slave_if.sv
// Bus interfaces between LoadStoreUnit (Master) and memory-mapped responders (Slave).
//   WriteIF: addr[31:0], valid, data[31:0], strb[3:0]   all driven by the master
//   ReadIF : addr[31:0], valid driven by the master; data[31:0] returned by the slave
// This file holds only these two bus interface declarations.

interface WriteIF;
   logic [31:0] addr;
   logic        valid;
   logic [31:0] data;
   logic [3:0]  strb;

   modport Master (output addr, output valid, output data, output strb);
   modport Slave  (input  addr, input  valid, input  data, input  strb);
endinterface

interface ReadIF;
   logic [31:0] addr;
   logic        valid;
   logic [31:0] data;

   modport Master (output addr, output valid, input  data);
   modport Slave  (input  addr, input  valid, output data);
endinterface

// File: rtl/timer_bus_slave.sv
// Memory-mapped machine timer (mtime/mtimecmp) on the load/store data bus.
// Register window of 32 bytes at BASE_ADDR, offset = addr[4:2]:
//   0 MTIME_LO, 1 MTIME_HI, 2 CMP_LO, 3 CMP_HI, 4 CTRL{irq_en,run}, 5 PRESC, 6/7 reserved.
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset
//   w_bus      WriteIF.Slave, byte-strobed registered writes
//   r_bus      ReadIF.Slave, combinational 0-cycle reads
//   r_hit      read valid and address inside the window
//   timer_irq  registered interrupt, irq_en && (mtime >= mtimecmp)
// Optional feature: define TIMER_SNAPSHOT_EN to make MTIME_HI reads return the high word
// captured when MTIME_LO was last read, giving a coherent LO-then-HI 64-bit read.

module timer_bus_slave #(
   parameter logic [31:0] BASE_ADDR  = 32'h0200_0000,
   parameter int unsigned PRESCALE_W = 16
) (
   input  logic  clk,
   input  logic  rst_n,
   WriteIF.Slave w_bus,
   ReadIF.Slave  r_bus,
   output logic  r_hit,
   output logic  timer_irq
);

   logic [63:0]           mtime_q, mtime_d;
   logic [63:0]           cmp_q, cmp_d;
   logic                  run_q, run_d;
   logic                  irq_en_q, irq_en_d;
   logic [PRESCALE_W-1:0] presc_q, presc_d;
   logic [PRESCALE_W-1:0] pc_q, pc_d;
   logic                  irq_q, irq_d;
   logic                  tick;
   logic                  w_sel;
   logic [2:0]            w_off, r_off;

   // Byte lanes are ignored; LoadStoreUnit handles lane extraction.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{w_bus.addr[1:0], r_bus.addr[1:0]};

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
      logic [31:0] res;
      for (int i = 0; i < 4; i++) begin
         res[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
      end
      return res;
   endfunction

   // strb == 0 is treated as no write at all, so it cannot drop a tick or clear pc.
   assign w_sel = w_bus.valid && (w_bus.addr[31:5] == BASE_ADDR[31:5]) && (w_bus.strb != 4'b0);
   assign w_off = w_bus.addr[4:2];
   assign r_off = r_bus.addr[4:2];
   assign r_hit = r_bus.valid && (r_bus.addr[31:5] == BASE_ADDR[31:5]);

`ifdef TIMER_SNAPSHOT_EN
   logic [31:0] hi_snap_q, hi_snap_d;
`endif

   always_comb begin
      tick     = run_q && (pc_q == presc_q);
      pc_d     = pc_q;
      mtime_d  = tick ? mtime_q + 64'd1 : mtime_q;
      cmp_d    = cmp_q;
      run_d    = run_q;
      irq_en_d = irq_en_q;
      presc_d  = presc_q;
      irq_d    = irq_en_q && (mtime_q >= cmp_q);
      if (run_q) begin
         pc_d = tick ? '0 : pc_q + 1'b1;
      end
      if (w_sel) begin
         case (w_off)
            // mtime writes start from the un-ticked value: the tick is dropped this cycle.
            3'd0: mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], w_bus.data, w_bus.strb)};
            3'd1: mtime_d = {merge_bytes(mtime_q[63:32], w_bus.data, w_bus.strb), mtime_q[31:0]};
            3'd2: cmp_d   = {cmp_q[63:32], merge_bytes(cmp_q[31:0], w_bus.data, w_bus.strb)};
            3'd3: cmp_d   = {merge_bytes(cmp_q[63:32], w_bus.data, w_bus.strb), cmp_q[31:0]};
            3'd4: begin
               run_d    = w_bus.strb[0] ? w_bus.data[0] : run_q;
               irq_en_d = w_bus.strb[0] ? w_bus.data[1] : irq_en_q;
            end
            3'd5: begin
               for (int b = 0; b < PRESCALE_W; b++) begin
                  if (w_bus.strb[b/8]) presc_d[b] = w_bus.data[b];
               end
               pc_d = '0;
            end
            default: ;
         endcase
      end
   end

`ifdef TIMER_SNAPSHOT_EN
   always_comb begin
      hi_snap_d = hi_snap_q;
      if (r_hit && (r_off == 3'd0)) hi_snap_d = mtime_q[63:32];
      if (w_sel && (w_off == 3'd1)) hi_snap_d = mtime_d[63:32];
   end
`endif

   always_comb begin
      r_bus.data = 32'h0;
      if (r_hit) begin
         case (r_off)
            3'd0: r_bus.data = mtime_q[31:0];
`ifdef TIMER_SNAPSHOT_EN
            3'd1: r_bus.data = hi_snap_q;
`else
            3'd1: r_bus.data = mtime_q[63:32];
`endif
            3'd2: r_bus.data = cmp_q[31:0];
            3'd3: r_bus.data = cmp_q[63:32];
            3'd4: r_bus.data = {30'b0, irq_en_q, run_q};
            3'd5: r_bus.data = 32'(presc_q);
            default: r_bus.data = 32'h0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mtime_q  <= 64'h0;
         cmp_q    <= 64'hFFFF_FFFF_FFFF_FFFF;
         run_q    <= 1'b0;
         irq_en_q <= 1'b0;
         presc_q  <= '0;
         pc_q     <= '0;
         irq_q    <= 1'b0;
      end else begin
         mtime_q  <= mtime_d;
         cmp_q    <= cmp_d;
         run_q    <= run_d;
         irq_en_q <= irq_en_d;
         presc_q  <= presc_d;
         pc_q     <= pc_d;
         irq_q    <= irq_d;
      end
   end

`ifdef TIMER_SNAPSHOT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) hi_snap_q <= 32'h0;
      else        hi_snap_q <= hi_snap_d;
   end
`endif

   assign timer_irq = irq_q;

endmodule

// File: tb/tb_timer_bus_slave.sv
// Self-checking bench for timer_bus_slave: directed scenarios plus a randomized run
// compared against a register-level reference model of the timer.

module tb_timer_bus_slave;

   localparam logic [31:0] Base = 32'h0200_0000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic r_hit, timer_irq;
   int   n_checks = 0;
   int   n_fail = 0;

   WriteIF w_bus ();
   ReadIF  r_bus ();

   timer_bus_slave #(.BASE_ADDR(Base), .PRESCALE_W(16)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .w_bus    (w_bus),
      .r_bus    (r_bus),
      .r_hit    (r_hit),
      .timer_irq(timer_irq)
   );

   always #5 clk = ~clk;

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [2:0] off, input logic [31:0] d, input logic [3:0] s);
      w_bus.addr  = Base | {27'd0, off, 2'b00};
      w_bus.data  = d;
      w_bus.strb  = s;
      w_bus.valid = 1'b1;
      cycles(1);
      w_bus.valid = 1'b0;
      w_bus.strb  = 4'b0;
   endtask

   task automatic rd(input logic [2:0] off, output logic [31:0] d);
      r_bus.addr  = Base | {27'd0, off, 2'b00};
      r_bus.valid = 1'b1;
      #1;
      d = r_bus.data;
      r_bus.valid = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] exp_v [6];
      logic [31:0] got;
      exp_v = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0};
      rst_n = 1'b0;
      // A write during reset must be overridden.
      w_bus.addr  = Base | 32'h8;
      w_bus.data  = 32'h1234_5678;
      w_bus.strb  = 4'hF;
      w_bus.valid = 1'b1;
      cycles(2);
      w_bus.valid = 1'b0;
      w_bus.strb  = 4'h0;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         rd(3'(i), got);
         n_checks++;
         if (got !== exp_v[i]) begin
            n_fail++;
            $display("FAIL reset_reg%0d got %h expected %h", i, got, exp_v[i]);
         end
      end
      n_checks++;
      if (timer_irq !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_irq got %b expected 0", timer_irq);
      end
   endtask

   task automatic test_decode();
      logic [31:0] exp_v [6];
      logic [31:0] got;
      exp_v = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0};
      // Writes just past the window and to reserved offsets.
      for (int i = 0; i < 8; i++) begin
         w_bus.addr  = Base + 32'h20 + 32'(i * 4);
         w_bus.data  = 32'h5A5A_5A5A;
         w_bus.strb  = 4'hF;
         w_bus.valid = 1'b1;
         cycles(1);
      end
      w_bus.valid = 1'b0;
      wr(3'd6, 32'h5A5A_5A5A, 4'hF);
      wr(3'd7, 32'h5A5A_5A5A, 4'hF);
      r_bus.addr  = Base + 32'h20;
      r_bus.valid = 1'b1;
      #1;
      n_checks++;
      if (r_hit !== 1'b0 || r_bus.data !== 32'h0) begin
         n_fail++;
         $display("FAIL decode_outside got hit=%b data=%h expected hit=0 data=0", r_hit, r_bus.data);
      end
      r_bus.addr = Base | 32'h1C;
      #1;
      n_checks++;
      if (r_hit !== 1'b1 || r_bus.data !== 32'h0) begin
         n_fail++;
         $display("FAIL decode_off7 got hit=%b data=%h expected hit=1 data=0", r_hit, r_bus.data);
      end
      r_bus.valid = 1'b0;
      #1;
      n_checks++;
      if (r_hit !== 1'b0) begin
         n_fail++;
         $display("FAIL decode_novalid got hit=%b expected 0", r_hit);
      end
      for (int i = 0; i < 6; i++) begin
         rd(3'(i), got);
         n_checks++;
         if (got !== exp_v[i]) begin
            n_fail++;
            $display("FAIL decode_unchanged%0d got %h expected %h", i, got, exp_v[i]);
         end
      end
   endtask

   task automatic test_strobe();
      logic [31:0] got;
      wr(3'd2, 32'hAABB_CCDD, 4'b0100);
      rd(3'd2, got);
      n_checks++;
      if (got !== 32'hFFBB_FFFF) begin
         n_fail++;
         $display("FAIL strobe_lane2 got %h expected FFBBFFFF", got);
      end
      wr(3'd2, 32'h0000_0000, 4'b0000);
      rd(3'd2, got);
      n_checks++;
      if (got !== 32'hFFBB_FFFF) begin
         n_fail++;
         $display("FAIL strobe_none got %h expected FFBBFFFF", got);
      end
      wr(3'd2, 32'h1122_3344, 4'b1001);
      rd(3'd2, got);
      n_checks++;
      if (got !== 32'h11BB_FF44) begin
         n_fail++;
         $display("FAIL strobe_lanes03 got %h expected 11BBFF44", got);
      end
   endtask

   task automatic test_carry();
      logic [31:0] lo, hi;
      wr(3'd0, 32'hFFFF_FFFF, 4'hF);
      wr(3'd1, 32'h0, 4'hF);
      wr(3'd5, 32'h0, 4'hF);
      wr(3'd4, 32'h1, 4'hF);
      rd(3'd0, lo);
      rd(3'd1, hi);
      n_checks++;
      if ({hi, lo} !== 64'h0000_0000_FFFF_FFFF) begin
         n_fail++;
         $display("FAIL carry_before got %h%h expected 00000000FFFFFFFF", hi, lo);
      end
      cycles(1);
      rd(3'd0, lo);
      rd(3'd1, hi);
      n_checks++;
      if (lo !== 32'h0 || hi !== 32'h1) begin
         n_fail++;
         $display("FAIL carry got hi=%h lo=%h expected hi=1 lo=0", hi, lo);
      end
      wr(3'd4, 32'h0, 4'hF);
      // All-ones wraps to zero.
      wr(3'd0, 32'hFFFF_FFFF, 4'hF);
      wr(3'd1, 32'hFFFF_FFFF, 4'hF);
      wr(3'd4, 32'h1, 4'hF);
      wr(3'd4, 32'h0, 4'hF);
      rd(3'd0, lo);
      rd(3'd1, hi);
      n_checks++;
      if ({hi, lo} !== 64'h0) begin
         n_fail++;
         $display("FAIL carry_wrap got %h%h expected 0", hi, lo);
      end
   endtask

   task automatic test_prescale();
      logic [31:0] lo;
      wr(3'd4, 32'h0, 4'hF);
      wr(3'd0, 32'h0, 4'hF);
      wr(3'd1, 32'h0, 4'hF);
      wr(3'd5, 32'h3, 4'hF);
      wr(3'd4, 32'h1, 4'hF);
      cycles(12);
      rd(3'd0, lo);
      n_checks++;
      if (lo !== 32'h3) begin
         n_fail++;
         $display("FAIL prescale_12 got %h expected 3", lo);
      end
      cycles(3);
      rd(3'd0, lo);
      n_checks++;
      if (lo !== 32'h3) begin
         n_fail++;
         $display("FAIL prescale_15 got %h expected 3", lo);
      end
      // This write lands on the tick edge: written value wins, no increment.
      wr(3'd0, 32'h100, 4'hF);
      rd(3'd0, lo);
      n_checks++;
      if (lo !== 32'h100) begin
         n_fail++;
         $display("FAIL prescale_collide got %h expected 100", lo);
      end
      cycles(3);
      rd(3'd0, lo);
      n_checks++;
      if (lo !== 32'h100) begin
         n_fail++;
         $display("FAIL prescale_after3 got %h expected 100", lo);
      end
      cycles(1);
      rd(3'd0, lo);
      n_checks++;
      if (lo !== 32'h101) begin
         n_fail++;
         $display("FAIL prescale_after4 got %h expected 101", lo);
      end
      wr(3'd4, 32'h0, 4'hF);
   endtask

   task automatic test_irq();
      logic [31:0] lo;
      logic        exp_irq;
      wr(3'd4, 32'h0, 4'hF);
      wr(3'd0, 32'h0, 4'hF);
      wr(3'd1, 32'h0, 4'hF);
      wr(3'd5, 32'h0, 4'hF);
      wr(3'd3, 32'h0, 4'hF);
      wr(3'd2, 32'd10, 4'hF);
      wr(3'd4, 32'h3, 4'hF);
      for (int k = 1; k <= 12; k++) begin
         cycles(1);
         exp_irq = (k >= 11);
         n_checks++;
         if (timer_irq !== exp_irq) begin
            n_fail++;
            $display("FAIL irq_rise_k%0d got %b expected %b", k, timer_irq, exp_irq);
         end
         if (k == 10) begin
            rd(3'd0, lo);
            n_checks++;
            if (lo !== 32'd10) begin
               n_fail++;
               $display("FAIL irq_mtime10 got %h expected a", lo);
            end
         end
      end
      wr(3'd2, 32'hFFFF_FFFF, 4'hF);
      n_checks++;
      if (timer_irq !== 1'b1) begin
         n_fail++;
         $display("FAIL irq_hold got %b expected 1", timer_irq);
      end
      cycles(1);
      n_checks++;
      if (timer_irq !== 1'b0) begin
         n_fail++;
         $display("FAIL irq_clear got %b expected 0", timer_irq);
      end
      wr(3'd4, 32'h0, 4'hF);
   endtask

   task automatic test_random();
      logic [63:0] m_mtime, m_cmp, n_mtime;
      logic        m_run, m_ien, m_irq, tick;
      logic [15:0] m_presc, m_pc;
      logic        wv, win, rv, rin;
      logic [2:0]  woff, roff;
      logic [31:0] wdat, word, exp_d;
      logic [3:0]  wstrb;
      logic        exp_hit;
      rst_n = 1'b0;
      cycles(1);
      rst_n = 1'b1;
      m_mtime = 64'h0;
      m_cmp   = '1;
      m_run   = 1'b0;
      m_ien   = 1'b0;
      m_irq   = 1'b0;
      m_presc = 16'h0;
      m_pc    = 16'h0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         wv    = 1'($urandom_range(0, 1));
         win   = ($urandom_range(0, 9) != 0);
         woff  = 3'($urandom_range(0, 7));
         wdat  = $urandom;
         wstrb = 4'($urandom_range(0, 15));
         if (woff == 3'd5) wdat = $urandom_range(0, 3);
         // Keep mtime near mtimecmp now and then so the interrupt toggles.
         if (woff == 3'd3 || woff == 3'd1) wdat = $urandom_range(0, 1);
         rv   = 1'($urandom_range(0, 1));
         rin  = ($urandom_range(0, 9) != 0);
         roff = 3'($urandom_range(0, 7));
         w_bus.addr  = (win ? Base : Base + 32'h20) | {27'd0, woff, 2'($urandom)};
         w_bus.data  = wdat;
         w_bus.strb  = wstrb;
         w_bus.valid = wv;
         r_bus.addr  = (rin ? Base : Base + 32'h40) | {27'd0, roff, 2'($urandom)};
         r_bus.valid = rv;
         #1;
         exp_hit = rv && rin;
         exp_d   = 32'h0;
         if (exp_hit) begin
            case (roff)
               3'd0: exp_d = m_mtime[31:0];
               3'd1: exp_d = m_mtime[63:32];
               3'd2: exp_d = m_cmp[31:0];
               3'd3: exp_d = m_cmp[63:32];
               3'd4: exp_d = {30'b0, m_ien, m_run};
               3'd5: exp_d = {16'b0, m_presc};
               default: exp_d = 32'h0;
            endcase
         end
         n_checks++;
         if (r_hit !== exp_hit || r_bus.data !== exp_d || timer_irq !== m_irq) begin
            n_fail++;
            $display("FAIL random_c%0d got hit=%b data=%h irq=%b expected hit=%b data=%h irq=%b",
                     cyc, r_hit, r_bus.data, timer_irq, exp_hit, exp_d, m_irq);
         end
         @(posedge clk);
         // Reference update for the edge just taken.
         m_irq   = m_ien && (m_mtime >= m_cmp);
         tick    = m_run && (m_pc == m_presc);
         n_mtime = tick ? m_mtime + 1 : m_mtime;
         if (m_run) m_pc = tick ? 16'h0 : m_pc + 16'h1;
         if (wv && win && wstrb != 4'b0) begin
            case (woff)
               3'd0, 3'd1: word = woff[0] ? m_mtime[63:32] : m_mtime[31:0];
               3'd2, 3'd3: word = woff[0] ? m_cmp[63:32] : m_cmp[31:0];
               3'd4:       word = {30'b0, m_ien, m_run};
               3'd5:       word = {16'b0, m_presc};
               default:    word = 32'h0;
            endcase
            for (int i = 0; i < 4; i++) if (wstrb[i]) word[8*i +: 8] = wdat[8*i +: 8];
            case (woff)
               3'd0: n_mtime = {m_mtime[63:32], word};
               3'd1: n_mtime = {word, m_mtime[31:0]};
               3'd2: m_cmp   = {m_cmp[63:32], word};
               3'd3: m_cmp   = {word, m_cmp[31:0]};
               3'd4: begin
                  m_run = word[0];
                  m_ien = word[1];
               end
               3'd5: begin
                  m_presc = word[15:0];
                  m_pc    = 16'h0;
               end
               default: ;
            endcase
         end
         m_mtime = n_mtime;
         #1;
      end
      w_bus.valid = 1'b0;
      r_bus.valid = 1'b0;
   endtask

   initial begin
      w_bus.addr  = 32'h0;
      w_bus.data  = 32'h0;
      w_bus.strb  = 4'h0;
      w_bus.valid = 1'b0;
      r_bus.addr  = 32'h0;
      r_bus.valid = 1'b0;
      #1;
      test_reset();
      test_decode();
      test_strobe();
      test_carry();
      test_prescale();
      test_irq();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
